muntjac_hart_ctrl: RTL

- Per-hart control block for a parametrised multi-hart Muntjac SoC. Sits between SoC-level interrupt and boot sources and NumHarts core wrappers.
- Releases hart resets one at a time, in a staggered sequence with a configurable gap, after a boot enable.
- Synchronises the asynchronous interrupt lines for each hart and gates them while that hart is held in reset.
- Drives a constant hart ID to each hart.

---
 rtl/muntjac_hart_ctrl_if.sv | 23 ++
 rtl/muntjac_hart_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/muntjac_hart_ctrl_if.sv
// rtl/muntjac_hart_ctrl_if.sv - per-hart interrupt bundle between SoC sources and the hart controller
interface muntjac_hart_ctrl_if #(
   parameter int unsigned NumHarts = 4
);
   logic [NumHarts-1:0] irq_software_m_i;
   logic [NumHarts-1:0] irq_timer_m_i;
   logic [NumHarts-1:0] irq_external_m_i;
   logic [NumHarts-1:0] irq_external_s_i;
   logic [NumHarts-1:0] irq_software_m_o;
   logic [NumHarts-1:0] irq_timer_m_o;
   logic [NumHarts-1:0] irq_external_m_o;
   logic [NumHarts-1:0] irq_external_s_o;

   modport master (
      output irq_software_m_i, irq_timer_m_i, irq_external_m_i, irq_external_s_i,
      input  irq_software_m_o, irq_timer_m_o, irq_external_m_o, irq_external_s_o
   );

   modport slave (
      input  irq_software_m_i, irq_timer_m_i, irq_external_m_i, irq_external_s_i,
      output irq_software_m_o, irq_timer_m_o, irq_external_m_o, irq_external_s_o
   );
endinterface

// File: rtl/muntjac_hart_ctrl.sv
// rtl/muntjac_hart_ctrl.sv - staggered hart reset release, interrupt synchronisation and hart IDs
module muntjac_hart_ctrl #(
   parameter int unsigned NumHarts   = 4,
   parameter logic [63:0] HartIdBase = 64'd0,
   parameter int unsigned ReleaseGap = 8,
   parameter int unsigned SyncStages = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     boot_en_i,
   input  logic [NumHarts-1:0]      hart_en_i,
   muntjac_hart_ctrl_if.slave       irq_if,
   output logic [NumHarts-1:0]      hart_rst_no,
   output logic [64*NumHarts-1:0]   hart_id_o,
   output logic                     boot_done_o
);
   localparam int unsigned IdxW   = (NumHarts > 1) ? $clog2(NumHarts) : 1;
   localparam int unsigned IrqW   = 4 * NumHarts;
   localparam int unsigned Stages = (SyncStages < 2) ? 2 : SyncStages;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumHarts - 1);
   localparam logic [7:0] GapInit = 8'((ReleaseGap == 0) ? 0 : ReleaseGap - 1);

   typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_e;

   state_e              state_q;
   logic [IdxW-1:0]     idx_q;
   logic [7:0]          cnt_q;
   logic [NumHarts-1:0] mask_q;
   logic [NumHarts-1:0] hart_rst_q;
   logic                done_q;

   // Dropping boot_en outranks every transition, including a release due this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         mask_q     <= '0;
         hart_rst_q <= '0;
         done_q     <= 1'b0;
      end else if (!boot_en_i && state_q != IDLE) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         hart_rst_q <= '0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (boot_en_i) begin
                  mask_q  <= hart_en_i;
                  idx_q   <= '0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (mask_q[idx_q]) hart_rst_q[idx_q] <= 1'b1;
               if (idx_q == LastIdx) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
                  if (mask_q[idx_q] && ReleaseGap != 0) begin
                     state_q <= WAIT;
                     cnt_q   <= GapInit;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) state_q <= SCAN;
               else             cnt_q   <= cnt_q - 8'd1;
            end
            DONE: state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hart_rst_no = hart_rst_q;
   assign boot_done_o = done_q;

   logic [IrqW-1:0] irq_in;
   logic [IrqW-1:0] irq_gated;
   logic [IrqW-1:0] sync_q [Stages];

   assign irq_in = {irq_if.irq_external_s_i, irq_if.irq_external_m_i,
                    irq_if.irq_timer_m_i, irq_if.irq_software_m_i};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned s = 0; s < Stages; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int unsigned s = 1; s < Stages; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Levels held across reset show up the same cycle the hart is released.
   assign irq_gated = sync_q[Stages-1] & {4{hart_rst_q}};

   assign irq_if.irq_software_m_o = irq_gated[0*NumHarts +: NumHarts];
   assign irq_if.irq_timer_m_o    = irq_gated[1*NumHarts +: NumHarts];
   assign irq_if.irq_external_m_o = irq_gated[2*NumHarts +: NumHarts];
   assign irq_if.irq_external_s_o = irq_gated[3*NumHarts +: NumHarts];

   for (genvar i = 0; i < NumHarts; i++) begin : g_hart_id
      assign hart_id_o[64*i +: 64] = HartIdBase + 64'(i);
   end
endmodule
